// File: rtl/p4_router_egress_port_buffer_if.sv
// p4_router_egress_port_buffer_if: ingress word stream and per-port egress AXI-Stream bundle
interface p4_router_egress_port_buffer_if #(
    parameter int NUM_EGR_PORTS = 4,
    parameter int DATA_BYTES = 64
);
    localparam int DEST_W = NUM_EGR_PORTS > 1 ? $clog2(NUM_EGR_PORTS) : 1;
    logic word_in_tvalid;
    logic [DATA_BYTES*8-1:0] word_in_tdata;
    logic [DATA_BYTES-1:0] word_in_tkeep;
    logic word_in_tlast;
    logic [DEST_W-1:0] word_in_tdest;
    logic [NUM_EGR_PORTS-1:0] egr_tvalid;
    logic [NUM_EGR_PORTS-1:0] egr_tready;
    logic [NUM_EGR_PORTS*DATA_BYTES*8-1:0] egr_tdata;
    logic [NUM_EGR_PORTS*DATA_BYTES-1:0] egr_tkeep;
    logic [NUM_EGR_PORTS-1:0] egr_tlast;
    logic [NUM_EGR_PORTS-1:0] egr_tuser_err;
    modport master (
        output word_in_tvalid, word_in_tdata, word_in_tkeep, word_in_tlast, word_in_tdest, egr_tready,
        input egr_tvalid, egr_tdata, egr_tkeep, egr_tlast, egr_tuser_err
    );
    modport slave (
        input word_in_tvalid, word_in_tdata, word_in_tkeep, word_in_tlast, word_in_tdest, egr_tready,
        output egr_tvalid, egr_tdata, egr_tkeep, egr_tlast, egr_tuser_err
    );
endinterface

// File: rtl/p4_router_egress_port_buffer.sv
// p4_router_egress_port_buffer: demuxes dequeued words into per-port FIFOs with truncation, credits and AXIS outputs
module p4_router_egress_port_buffer #(
    parameter int NUM_EGR_PORTS = 4,
    parameter int DATA_BYTES = 64,
    parameter int FIFO_DEPTH_WORDS = 64,
    parameter int MTU_BYTES = 2000,
    parameter int READY_SLACK_WORDS = 4
) (
    input  logic clk,
    input  logic aresetn,
    p4_router_egress_port_buffer_if.slave bus,
    input  logic cnt_clear,
    output logic [NUM_EGR_PORTS-1:0] egr_buf_ready,
    output logic [NUM_EGR_PORTS-1:0] overflow_sticky,
    output logic bad_dest_sticky,
    output logic [15:0] trunc_pkt_cnt
);
    localparam int DW = DATA_BYTES * 8;
    localparam int MTU_WORDS = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int AW = FIFO_DEPTH_WORDS > 1 ? $clog2(FIFO_DEPTH_WORDS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH_WORDS + 1);
    localparam int DEST_W = NUM_EGR_PORTS > 1 ? $clog2(NUM_EGR_PORTS) : 1;

    if (NUM_EGR_PORTS < 1) begin : g_bad_ports
        $error("NUM_EGR_PORTS must be > 0");
    end
    if ((FIFO_DEPTH_WORDS & (FIFO_DEPTH_WORDS - 1)) != 0) begin : g_bad_pow2
        $error("FIFO_DEPTH_WORDS must be a power of 2");
    end
    if (FIFO_DEPTH_WORDS < MTU_WORDS + READY_SLACK_WORDS + 1) begin : g_bad_depth
        $error("FIFO_DEPTH_WORDS too small for MTU plus ready slack");
    end

    typedef enum logic {ACCEPT, DISCARD} state_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic [DATA_BYTES-1:0] keep;
        logic last;
        logic err;
    } entry_t;

    entry_t mem_q [NUM_EGR_PORTS][FIFO_DEPTH_WORDS];
    entry_t out_q [NUM_EGR_PORTS];
    entry_t out_d [NUM_EGR_PORTS];
    state_t state_q [NUM_EGR_PORTS];
    state_t state_d [NUM_EGR_PORTS];
    logic [AW-1:0] wr_ptr_q [NUM_EGR_PORTS];
    logic [AW-1:0] wr_ptr_d [NUM_EGR_PORTS];
    logic [AW-1:0] rd_ptr_q [NUM_EGR_PORTS];
    logic [AW-1:0] rd_ptr_d [NUM_EGR_PORTS];
    logic [CW-1:0] cnt_q [NUM_EGR_PORTS];
    logic [CW-1:0] cnt_d [NUM_EGR_PORTS];
    logic [NUM_EGR_PORTS-1:0] ovld_q, ovld_d, ready_q, ready_d, ovf_q, ovf_d;
    logic [NUM_EGR_PORTS-1:0] sel, wr_en, ovf_ev, pop, load;
    logic bad_q, bad_d;
    logic [15:0] trunc_q, trunc_d;
    logic dest_ok, wr_trunc, any_ovf;
    entry_t wr_entry;

    always_comb begin
        dest_ok = 32'(bus.word_in_tdest) < 32'(NUM_EGR_PORTS);
        wr_trunc = 1'b0;
        any_ovf = 1'b0;
        for (int p = 0; p < NUM_EGR_PORTS; p++) begin
            sel[p] = bus.word_in_tvalid && dest_ok && bus.word_in_tdest == DEST_W'(p);
            wr_en[p] = sel[p] && state_q[p] == ACCEPT && cnt_q[p] != CW'(FIFO_DEPTH_WORDS);
            ovf_ev[p] = sel[p] && state_q[p] == ACCEPT && (cnt_q[p] == CW'(FIFO_DEPTH_WORDS) ||
                        (cnt_q[p] == CW'(FIFO_DEPTH_WORDS - 1) && !bus.word_in_tlast));
            state_d[p] = !sel[p] ? state_q[p] : bus.word_in_tlast ? ACCEPT :
                         (ovf_ev[p] || state_q[p] == DISCARD) ? DISCARD : ACCEPT;
            wr_trunc = wr_trunc | (wr_en[p] && ovf_ev[p]);
            any_ovf = any_ovf | ovf_ev[p];
            pop[p] = ovld_q[p] && bus.egr_tready[p];
            load[p] = cnt_q[p] > CW'(ovld_q[p]) && (!ovld_q[p] || pop[p]);
            ovld_d[p] = load[p] || (ovld_q[p] && !pop[p]);
            out_d[p] = load[p] ? mem_q[p][rd_ptr_q[p]] : out_q[p];
            rd_ptr_d[p] = rd_ptr_q[p] + AW'(load[p]);
            wr_ptr_d[p] = wr_ptr_q[p] + AW'(wr_en[p]);
            cnt_d[p] = cnt_q[p] + CW'(wr_en[p]) - CW'(pop[p]);
            ready_d[p] = (CW'(FIFO_DEPTH_WORDS) - cnt_q[p]) >= CW'(MTU_WORDS + READY_SLACK_WORDS);
        end
        wr_entry = '{data: bus.word_in_tdata, keep: bus.word_in_tkeep,
                     last: bus.word_in_tlast | wr_trunc, err: wr_trunc};
        ovf_d = cnt_clear ? '0 : ovf_q | ovf_ev;
        bad_d = cnt_clear ? 1'b0 : bad_q | (bus.word_in_tvalid && !dest_ok);
        trunc_d = cnt_clear ? 16'd0 : (any_ovf && trunc_q != 16'hFFFF) ? trunc_q + 16'd1 : trunc_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= '{default: ACCEPT};
            out_q <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q <= '{default: '0};
            ovld_q <= '0;
            ready_q <= '0;
            ovf_q <= '0;
            bad_q <= 1'b0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            out_q <= out_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            ovld_q <= ovld_d;
            ready_q <= ready_d;
            ovf_q <= ovf_d;
            bad_q <= bad_d;
            trunc_q <= trunc_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_EGR_PORTS; p++) begin
            if (wr_en[p]) mem_q[p][wr_ptr_q[p]] <= wr_entry;
        end
    end

    always_comb begin
        bus.egr_tdata = '0;
        bus.egr_tkeep = '0;
        bus.egr_tlast = '0;
        bus.egr_tuser_err = '0;
        for (int p = 0; p < NUM_EGR_PORTS; p++) begin
            bus.egr_tdata[p*DW +: DW] = out_q[p].data;
            bus.egr_tkeep[p*DATA_BYTES +: DATA_BYTES] = out_q[p].keep;
            bus.egr_tlast[p] = out_q[p].last;
            bus.egr_tuser_err[p] = out_q[p].err;
        end
    end

    assign bus.egr_tvalid = ovld_q;
    assign egr_buf_ready = ready_q;
    assign overflow_sticky = ovf_q;
    assign bad_dest_sticky = bad_q;
    assign trunc_pkt_cnt = trunc_q;
endmodule
